// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame geometry constants, writer state enum and row address helper
package frame_pkg;

    localparam int WIDTH         = 640;
    localparam int HEIGHT        = 480;
    localparam int BPP           = 3;
    localparam int WORD_PIX      = 8;
    localparam int WORD_W        = WORD_PIX * BPP;
    localparam int WORDS_PER_ROW = WIDTH / WORD_PIX;
    localparam int FB_ADDR_W     = 16;
    localparam int CNT_W         = 7;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } fw_state_t;

    // row*80 as a shift-add so no multiplier is inferred
    function automatic logic [FB_ADDR_W-1:0] row_base(input logic [8:0] row);
        return FB_ADDR_W'({row, 6'b0}) + FB_ADDR_W'({row, 4'b0});
    endfunction

endpackage

// File: rtl/frame_row_writer.sv
// rtl/frame_row_writer.sv - moves one received pixel row into the frame RAM around VGA reads
module frame_row_writer
    import frame_pkg::*;
#(
    parameter int WIDTH    = frame_pkg::WIDTH,
    parameter int HEIGHT   = frame_pkg::HEIGHT,
    parameter int BPP      = frame_pkg::BPP,
    parameter int WORD_PIX = frame_pkg::WORD_PIX,
    parameter int ADDR_W   = frame_pkg::FB_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      row_done,
    input  logic [8:0]                row_num,
    input  logic [WIDTH*BPP-1:0]      row_data,
    input  logic                      vga_rd_req,
    input  logic [ADDR_W-1:0]         vga_rd_addr,
    output logic                      vga_rd_gnt,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [WORD_PIX*BPP-1:0]   mem_wdata,
    output logic                      busy,
    output logic                      wr_done,
    output logic                      row_err,
    output logic                      overflow
);

    localparam int ROW_W = WIDTH * BPP;
    localparam int WW    = WORD_PIX * BPP;
    localparam int WPR   = WIDTH / WORD_PIX;
    localparam int SEL_W = $clog2(ROW_W);

    fw_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ROW_W-1:0]  row_reg;
    logic [SEL_W-1:0]  sel;
    logic              wr_slot;
    logic              last_word;
    logic              row_ok;

    // A write slot is any WRITE cycle the VGA reader leaves free; reset kills it at once
    assign wr_slot    = rst_n && (state == WRITE) && !vga_rd_req;
    assign last_word  = (cnt == CNT_W'(WPR - 1));
    assign row_ok     = (32'(row_num) < HEIGHT);
    assign sel        = SEL_W'(cnt) * SEL_W'(WW);
    assign mem_wdata  = row_reg[sel +: WW];
    assign mem_we     = wr_slot;
    assign vga_rd_gnt = vga_rd_req;

    // Port mux: VGA owns the address whenever it asks, otherwise the current row word
    always_comb begin
        mem_addr = '0;
        if (vga_rd_req) begin
            mem_addr = vga_rd_addr;
        end else if (rst_n && state == WRITE) begin
            mem_addr = base + ADDR_W'(cnt);
        end
    end

    // Transfer FSM with registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            busy     <= 1'b0;
            wr_done  <= 1'b0;
            row_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_done  <= 1'b0;
            row_err  <= 1'b0;
            overflow <= row_done && (state != IDLE);
            case (state)
                IDLE: begin
                    if (row_done) begin
                        if (row_ok) begin
                            row_reg <= row_data;
                            base    <= ADDR_W'(row_base(row_num));
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            row_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!vga_rd_req) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            wr_done <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_row_writer.md
# frame_row_writer

Schedules the transfer of one received pixel row, 640 pixels × 3 bpp = 1920 bits, into the single-port frame buffer RAM. It shares the RAM port with the VGA scan-out reader.
- Sits between `UART_Controller` (its `done`/`row`/`uart_data` outputs) and the frame RAM.
- VGA reads have absolute priority; row writes fill the remaining cycles.
- Flags invalid rows and rows that arrive while a transfer is still in progress.

## Interface
Parameters:
- `WIDTH`, 640: pixels per row
- `HEIGHT`, 480: rows per frame
- `BPP`, 3: bits per pixel
- `WORD_PIX`, 8: pixels per RAM word (word width 24)
- `ADDR_W`, 16: frame RAM address width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `row_done`  in  1  one-cycle pulse: row data valid
- `row_num`  in  9  row index for `row_data`
- `row_data`  in  `WIDTH*BPP`  packed row; pixel p occupies bits [3p+2:3p]
- `vga_rd_req`  in  1  VGA wants the RAM port this cycle
- `vga_rd_addr`  in  `ADDR_W`  VGA read address
- `vga_rd_gnt`  out  1  port granted to VGA (equals `vga_rd_req`)
- `mem_addr`  out  `ADDR_W`  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  24  RAM write data
- `busy`  out  1  transfer in progress
- `wr_done`  out  1  one-cycle pulse: row fully written
- `row_err`  out  1  one-cycle pulse: `row_num` ≥ `HEIGHT`, row dropped
- `overflow`  out  1  one-cycle pulse: `row_done` while busy, row dropped

## Operation
Derived constant: `WORDS_PER_ROW` = `WIDTH/WORD_PIX` = 80.

State machine:
- **IDLE**
  - On `row_done` with `row_num` < `HEIGHT`: latch `row_data` into the row register, compute base address = `row_num*80` as (`row_num`<<6)+(`row_num`<<4) zero-extended to `ADDR_W`, clear word counter `cnt` (7 bits), go to WRITE.
  - On `row_done` with `row_num` ≥ `HEIGHT`: pulse `row_err` next cycle, stay in IDLE.
- **WRITE**
  - When `vga_rd_req`=0: `mem_we`=1, `mem_addr`=base+`cnt`, `mem_wdata`=row word `cnt` (bits [24·cnt+23:24·cnt]), then `cnt`++.
  - When `vga_rd_req`=1: no write, `cnt` holds.
  - On the write with `cnt`=79: go to FINISH.
- **FINISH**
  - `wr_done`=1; go to IDLE.

Port arbitration and output rules:
- Port mux is combinational: `mem_addr`=`vga_rd_addr` whenever `vga_rd_req`=1, regardless of state; otherwise base+`cnt` in WRITE, else 0.
- `mem_we` is never 1 in the same cycle as `vga_rd_gnt`.
- `busy`=1 in WRITE and FINISH.
- `row_done` in WRITE or FINISH: row discarded, `overflow` pulses next cycle, the transfer in progress is unaffected.
- No write starvation guard: a continuously asserted `vga_rd_req` stalls WRITE indefinitely. The VGA controller's blanking intervals guarantee progress.

Reset values:
- `rst_n`=0 forces IDLE and clears `cnt`.
- `busy`, `wr_done`, `row_err`, `overflow` and `mem_we` are all 0 during reset and in the cycle after reset.
- `mem_addr`=0 unless `vga_rd_req`=1.
- Reset in the middle of WRITE abandons the row. Partially written words remain in RAM and are not rolled back.

## Timing
Transfer with no contention, `row_done` at cycle T:
- WRITE occupies T+1..T+80 (word k written at T+1+k).
- FINISH and `wr_done` at T+81.
- IDLE at T+82; the earliest accepted `row_done` is at T+82.

With contention:
- Each cycle with `vga_rd_req`=1 during WRITE adds exactly one cycle to the transfer.
- `vga_rd_gnt`, `mem_we` and `mem_addr` are combinational from state and `vga_rd_req`: zero-cycle grant.

Flags:
- `row_err` and `overflow` are registered, asserted at T+1 for a `row_done` at T.
- `busy` is registered from state: high T+1..T+81.

## Structure
Shared package `frame_pkg`:
- Constants `WIDTH`, `HEIGHT`, `BPP`, `WORD_PIX`, `WORD_W`=24, `WORDS_PER_ROW`=80, `FB_ADDR_W`=16.
- State enum `fw_state_t` {IDLE, WRITE, FINISH}.

No sub-module needed: the word select is an indexed part-select of the row register, and the address is a shift-add.

## Test plan
- Single row, `row_num`=5, `vga_rd_req`=0, distinct word values → writes to 400..479 at T+1..T+80 with matching data, `wr_done` at T+81, `busy` high T+1..T+81.
- Row 479 with `vga_rd_req` toggled every other cycle → all 80 words written to 38320..38399, never with `mem_we`&`vga_rd_gnt`, `wr_done` at T+161.
- `row_num`=480 → `row_err` at T+1, no `mem_we`, `busy` stays 0.
- `row_done` for row 7 at T+40 during row 3's transfer → `overflow` at T+41, row 3 completes intact, nothing written to 560..639.
- `rst_n` low at T+30 during WRITE → `mem_we`=0 and `busy`=0 from T+31; a new row at T+40 writes all 80 words normally.
- `vga_rd_req` held high for 200 cycles in WRITE → `cnt` frozen, `mem_addr`=`vga_rd_addr`; the transfer resumes with the correct word when `vga_rd_req` falls.
